// File: rtl/pcap_replay_pkg.sv
// Shared definitions for the pcap replay pacer: FSM state encoding and
// default counter widths.
package pcap_replay_pkg;

    localparam int unsigned DEF_GAP_WIDTH     = 32;
    localparam int unsigned DEF_PKT_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } pacer_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-register AXI4-Stream slice with an external gate on tready.
// A beat accepted at one edge is presented on the master side at the next.
module axis_reg_slice #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    gate,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [TUSER_WIDTH-1:0]  s_tuser,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [TUSER_WIDTH-1:0]  m_tuser,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready
);

    always_comb begin
        s_tready = gate && (!m_tvalid || m_tready);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tstrb  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tstrb  <= s_tstrb;
            m_tuser  <= s_tuser;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pcap_replay_pacer.sv
// Paces the replayed packet stream: programmable inter-packet gap and an
// optional per-run packet limit, in front of a one-beat output register.
module pcap_replay_pacer
    import pcap_replay_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_GAP_WIDTH          = DEF_GAP_WIDTH,
    parameter int C_PKT_CNT_WIDTH      = DEF_PKT_CNT_WIDTH
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              sw_rst,
    input  logic                              enable,
    input  logic [C_GAP_WIDTH-1:0]            ifg_cycles,
    input  logic [C_PKT_CNT_WIDTH-1:0]        pkt_limit,
    output logic [C_PKT_CNT_WIDTH-1:0]        pkt_count,
    output logic                              busy,
    output logic                              done,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
);

    pacer_state_t               state_q, state_d;
    logic [C_PKT_CNT_WIDTH-1:0] limit_q, limit_d;
    logic [C_PKT_CNT_WIDTH-1:0] count_d, count_inc;
    logic [C_GAP_WIDTH-1:0]     gap_q, gap_d;
    logic                       srst;
    logic                       gate;
    logic                       accept;

    always_comb begin
        srst      = !axi_aresetn || sw_rst;
        accept    = s_axis_tvalid && s_axis_tready;
        count_inc = (pkt_count == '1) ? pkt_count : pkt_count + 1'b1;
    end

    always_ff @(posedge axi_aclk) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            limit_q   <= '0;
            pkt_count <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            pkt_count <= count_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        count_d = pkt_count;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    limit_d = pkt_limit;
                    count_d = '0;
                    state_d = ST_PASS;
                end
            end
            ST_PASS, ST_GAP: begin
                if (state_q == ST_GAP && gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (state_q == ST_GAP && !enable) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    // A single-beat packet accepted out of GAP is handled
                    // exactly like a tlast in PASS.
                    if (s_axis_tlast) begin
                        count_d = count_inc;
                        gap_d   = ifg_cycles;
                        if (limit_q != '0 && count_inc == limit_q) begin
                            state_d = ST_DONE;
                        end else if (!enable) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        state_d = ST_PASS;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gate = (state_q == ST_PASS) ||
               (state_q == ST_GAP && gap_q == '0 && enable);
        busy = (state_q == ST_PASS) || (state_q == ST_GAP);
        done = (state_q == ST_DONE);
    end

    axis_reg_slice #(
        .DATA_WIDTH  (C_M_AXIS_DATA_WIDTH),
        .TUSER_WIDTH (C_M_AXIS_TUSER_WIDTH)
    ) u_out_slice (
        .clk      (axi_aclk),
        .srst     (srst),
        .gate     (gate),
        .s_tdata  (s_axis_tdata),
        .s_tstrb  (s_axis_tstrb),
        .s_tuser  (s_axis_tuser),
        .s_tvalid (s_axis_tvalid),
        .s_tlast  (s_axis_tlast),
        .s_tready (s_axis_tready),
        .m_tdata  (m_axis_tdata),
        .m_tstrb  (m_axis_tstrb),
        .m_tuser  (m_axis_tuser),
        .m_tvalid (m_axis_tvalid),
        .m_tlast  (m_axis_tlast),
        .m_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_pcap_replay_pacer.sv
// Directed plus randomized bench for pcap_replay_pacer: a negedge monitor
// keeps a beat scoreboard, latency/stall/gap rules and a tlast tally.
module tb_pcap_replay_pacer;

    localparam int DW = 32;
    localparam int UW = 16;
    localparam int GW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          axi_aresetn, sw_rst, enable;
    logic [GW-1:0] ifg_cycles;
    logic [CW-1:0] pkt_limit, pkt_count;
    logic          busy, done;
    logic [DW-1:0] s_axis_tdata, m_axis_tdata;
    logic [DW/8-1:0] s_axis_tstrb, m_axis_tstrb;
    logic [UW-1:0] s_axis_tuser, m_axis_tuser;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

    pcap_replay_pacer #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .C_GAP_WIDTH          (GW),
        .C_PKT_CNT_WIDTH      (CW)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (axi_aresetn),
        .sw_rst        (sw_rst),
        .enable        (enable),
        .ifg_cycles    (ifg_cycles),
        .pkt_limit     (pkt_limit),
        .pkt_count     (pkt_count),
        .busy          (busy),
        .done          (done),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        logic [UW-1:0]   u;
        logic            l;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    total_tlast = 0;
    int    stall_seen = 0;
    int    base = 0;
    beat_t exp_q[$];
    int    in_cyc[$];
    int    out_cyc[$];
    int    tr_mode = 0;
    int    pat_idx = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_count();
        int d;
        d = total_tlast - base;
        return (d > 255) ? 255 : d;
    endfunction

    // m_axis_tready: 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 left to main
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            2: begin
                m_axis_tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end
            default: ;
        endcase
    end

    beat_t prev_beat, last_out;
    logic  prev_s_acc = 1'b0, prev_stall = 1'b0, in_pkt = 1'b0, have_tlast = 1'b0;
    int    tlast_cyc = 0, tlast_ifg = 0;

    always @(negedge clk) begin
        beat_t cur_in, cur_out;
        logic  s_acc;
        cyc++;
        cur_in  = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
        cur_out = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
        if (!axi_aresetn || sw_rst) begin
            exp_q.delete();
            prev_s_acc = 1'b0;
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
            have_tlast = 1'b0;
        end else begin
            if (prev_s_acc) begin
                check("latency_valid", 64'(m_axis_tvalid), 64'd1);
                check("latency_beat", 64'(cur_out), 64'(prev_beat));
            end
            if (prev_stall) begin
                stall_seen++;
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_hold", 64'(cur_out), 64'(last_out));
            end
            if (!enable) have_tlast = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                out_cyc.push_back(cyc);
                check("order_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("order_beat", 64'(cur_out), 64'(exp_q.pop_front()));
            end
            s_acc = s_axis_tvalid && s_axis_tready;
            if (s_acc) begin
                if (!in_pkt && have_tlast)
                    check("ifg_min", 64'((cyc - tlast_cyc) >= tlast_ifg + 1), 64'd1);
                exp_q.push_back(cur_in);
                in_cyc.push_back(cyc);
                in_pkt = !s_axis_tlast;
                if (s_axis_tlast) begin
                    have_tlast = 1'b1;
                    tlast_cyc  = cyc;
                    tlast_ifg  = int'(ifg_cycles);
                    total_tlast++;
                end
            end
            prev_s_acc = s_acc;
            prev_beat  = cur_in;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            last_out   = cur_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tstrb  = DW'($urandom) >> (DW - DW/8);
        s_axis_tuser  = UW'($urandom);
        s_axis_tlast  = last;
    endtask

    task automatic wait_acc(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = s_axis_tready;
            tick();
            if (ok) return;
        end
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_pkt(input int len);
        logic ok;
        for (int i = 0; i < len; i++) begin
            drive_beat(i == len - 1);
            wait_acc(ok);
            if (!ok) break;
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0, o0, s0;
        logic ok;
        axi_aresetn = 1'b0; sw_rst = 1'b0; enable = 1'b0;
        ifg_cycles = '0; pkt_limit = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        tick(); axi_aresetn = 1'b1; tick();

        // three 2-beat packets, no gap
        ifg_cycles = 8'd0; pkt_limit = '0; enable = 1'b1; base = total_tlast;
        tick();
        n0 = in_cyc.size(); o0 = out_cyc.size();
        for (int p = 0; p < 3; p++) send_pkt(2);
        repeat (3) tick();
        @(negedge clk);
        check("t1_in_count", 64'(in_cyc.size() - n0), 64'd6);
        for (int i = 1; i < 6; i++) begin
            check("t1_in_consec", 64'(in_cyc[n0+i] - in_cyc[n0]), 64'(i));
            check("t1_out_latency", 64'(out_cyc[o0+i] - in_cyc[n0]), 64'(i + 1));
        end
        check("t1_pkt_count", 64'(pkt_count), 64'(exp_count()));
        check("t1_busy", 64'(busy), 64'd1);

        // ifg 5 between two single-beat packets
        tick(); ifg_cycles = 8'd5;
        n0 = in_cyc.size(); o0 = out_cyc.size();
        send_pkt(1);
        send_pkt(1);
        repeat (3) tick();
        @(negedge clk);
        check("t2_in_gap", 64'(in_cyc[n0+1] - in_cyc[n0]), 64'd6);
        check("t2_out_gap", 64'(out_cyc[o0+1] - out_cyc[o0]), 64'd6);
        check("t2_pkt_count", 64'(pkt_count), 64'(exp_count()));

        // packet limit 2
        tick(); enable = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("t3_idle_busy", 64'(busy), 64'd0);
        tick(); pkt_limit = 8'd2; ifg_cycles = 8'd1; enable = 1'b1; base = total_tlast;
        tick();
        send_pkt($urandom_range(1, 3));
        send_pkt($urandom_range(1, 3));
        n0 = in_cyc.size();
        drive_beat(1'b1);
        repeat (10) tick();
        @(negedge clk);
        check("t3_no_extra", 64'(in_cyc.size() - n0), 64'd0);
        check("t3_done", 64'(done), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_s_tready", 64'(s_axis_tready), 64'd0);
        check("t3_pkt_count", 64'(pkt_count), 64'd2);
        tick(); enable = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("t3_off_done", 64'(done), 64'd0);
        check("t3_off_busy", 64'(busy), 64'd0);
        tick(); pkt_limit = '0; enable = 1'b1; base = total_tlast;
        tick();
        @(negedge clk);
        check("t3_restart_count", 64'(pkt_count), 64'd0);
        check("t3_restart_busy", 64'(busy), 64'd1);
        tick(); s_axis_tvalid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("t3_resume_in", 64'(in_cyc.size() - n0), 64'd1);
        check("t3_resume_count", 64'(pkt_count), 64'(exp_count()));

        // tready pattern 1,0,0,1 during a 4-beat packet
        tick(); ifg_cycles = 8'd0; pat_idx = 0; tr_mode = 2;
        s0 = stall_seen; o0 = out_cyc.size();
        send_pkt(4);
        repeat (10) tick();
        tr_mode = 0;
        tick();
        @(negedge clk);
        check("t4_out_count", 64'(out_cyc.size() - o0), 64'd4);
        check("t4_stalled", 64'(stall_seen > s0), 64'd1);
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // randomized packets, gaps and backpressure
        tick(); tr_mode = 1;
        for (int p = 0; p < 12; p++) begin
            ifg_cycles = GW'($urandom_range(0, 3));
            send_pkt($urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) tick();
        end
        tr_mode = 0;
        repeat (20) tick();
        @(negedge clk);
        check("rnd_drained", 64'(exp_q.size()), 64'd0);
        check("rnd_pkt_count", 64'(pkt_count), 64'(exp_count()));

        // enable dropped on beat 2 of a 4-beat packet
        tick(); ifg_cycles = 8'd2;
        n0 = in_cyc.size();
        drive_beat(1'b0); wait_acc(ok);
        drive_beat(1'b0); enable = 1'b0; wait_acc(ok);
        drive_beat(1'b0); wait_acc(ok);
        drive_beat(1'b1); wait_acc(ok);
        s_axis_tvalid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("t5_all_in", 64'(in_cyc.size() - n0), 64'd4);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_s_tready", 64'(s_axis_tready), 64'd0);
        check("t5_pkt_count", 64'(pkt_count), 64'(exp_count()));

        // sw_rst, then axi_aresetn, on beat 2 of a 3-beat packet
        for (int r = 0; r < 2; r++) begin
            tick(); tr_mode = 0; ifg_cycles = 8'd0; enable = 1'b1; base = total_tlast;
            tick();
            send_pkt(1);
            drive_beat(1'b0); wait_acc(ok);
            tr_mode = 3; m_axis_tready = 1'b0;
            drive_beat(1'b0);
            if (r == 0) sw_rst = 1'b1; else axi_aresetn = 1'b0;
            tick();
            sw_rst = 1'b0; axi_aresetn = 1'b1; s_axis_tvalid = 1'b0;
            @(negedge clk);
            check(r == 0 ? "t6_sw_m_tvalid" : "t6_hw_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            check(r == 0 ? "t6_sw_pkt_count" : "t6_hw_pkt_count", 64'(pkt_count), 64'd0);
            check(r == 0 ? "t6_sw_busy" : "t6_hw_busy", 64'(busy), 64'd0);
            check(r == 0 ? "t6_sw_done" : "t6_hw_done", 64'(done), 64'd0);
            check(r == 0 ? "t6_sw_s_tready" : "t6_hw_s_tready", 64'(s_axis_tready), 64'd0);
            tick(); m_axis_tready = 1'b1; tr_mode = 0; enable = 1'b0;
            repeat (2) tick();
        end

        // pkt_count saturation
        tick(); ifg_cycles = 8'd0; pkt_limit = '0; enable = 1'b1; base = total_tlast;
        tick();
        for (int p = 0; p < 260; p++) send_pkt(1);
        repeat (3) tick();
        @(negedge clk);
        check("sat_pkt_count", 64'(pkt_count), 64'(exp_count()));
        check("sat_busy", 64'(busy), 64'd1);
        check("sat_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
